// File: rtl/inst_queue_pkg.sv
// Shared types for the dual-lane instruction queue: fetch exception codes,
// the fetch entry payload, and a lane-count helper for thermometer masks.
package inst_queue_pkg;

    typedef enum logic [3:0] {
        EXC_NONE = 4'd0,
        EXC_INT  = 4'd1,
        EXC_ADEF = 4'd2,
        EXC_PIF  = 4'd3,
        EXC_PPI  = 4'd4,
        EXC_TLBR = 4'd5,
        EXC_INE  = 4'd6,
        EXC_SYS  = 4'd7,
        EXC_BRK  = 4'd8,
        EXC_ALE  = 4'd9
    } exception_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        have_exception;
        exception_t  exception_type;
        logic        pred_branch_taken;
        logic [31:0] pred_branch_target;
    } fetch_entry_t;

    // Non-thermometer masks (2'b10) count as zero lanes.
    function automatic logic [1:0] lane_count(input logic [1:0] mask);
        logic [1:0] n;
        n = 2'd0;
        if (mask == 2'b11) begin
            n = 2'd2;
        end else if (mask == 2'b01) begin
            n = 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// Entry storage for the instruction queue: two write ports, two
// combinational read ports, no reset on the array.
module inst_queue_ram
    import inst_queue_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [1:0]        i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr0,
    input  logic [ADDR_W-1:0] i_wr_addr1,
    input  fetch_entry_t      i_wr_data0,
    input  fetch_entry_t      i_wr_data1,
    input  logic [ADDR_W-1:0] i_rd_addr0,
    input  logic [ADDR_W-1:0] i_rd_addr1,
    output fetch_entry_t      o_rd_data0,
    output fetch_entry_t      o_rd_data1
);

    fetch_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en[0]) begin
            r_mem[i_wr_addr0] <= i_wr_data0;
        end
        if (i_wr_en[1]) begin
            r_mem[i_wr_addr1] <= i_wr_data1;
        end
    end

    assign o_rd_data0 = r_mem[i_rd_addr0];
    assign o_rd_data1 = r_mem[i_rd_addr1];

endmodule

// File: rtl/inst_queue.sv
// Dual-lane in-order instruction FIFO between fetch and decode.
// Optional same-cycle empty bypass: define INST_QUEUE_BYPASS_EN.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic [1:0]         in_valid,
    output logic               in_ready,
    input  fetch_entry_t [1:0] in_entry,
    output logic [1:0]         out_valid,
    output fetch_entry_t [1:0] out_entry,
    input  logic [1:0]         out_pop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ACCEPT_MAX = CNT_W'(DEPTH - 2);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_in_ready;
    logic             w_bypass;
    logic [1:0]       w_push_n;
    logic [1:0]       w_pop_n;
    logic             w_pop0;
    logic             w_pop1;
    logic [1:0]       w_head_adv;
    logic [1:0]       w_tail_adv;
    logic [1:0]       w_out_valid;
    fetch_entry_t     w_lane0;
    fetch_entry_t     w_lane1;
    fetch_entry_t     w_rd_data0;
    fetch_entry_t     w_rd_data1;
    logic [1:0]       w_wr_en;
    fetch_entry_t     w_wr_data0;
    fetch_entry_t     w_wr_data1;
    logic [PTR_W-1:0] w_head_p1;
    logic [PTR_W-1:0] w_tail_p1;

    // Registered count only, so there is no path from in_valid/out_pop.
    assign w_in_ready = (r_count <= CNT_ACCEPT_MAX);
    assign in_ready   = w_in_ready;

`ifdef INST_QUEUE_BYPASS_EN
    assign w_bypass = (r_count == '0) && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push_n  = (w_in_ready && !flush) ? lane_count(in_valid) : 2'd0;
    assign w_head_p1 = r_head + PTR_W'(1);
    assign w_tail_p1 = r_tail + PTR_W'(1);

    inst_queue_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk        (clk),
        .i_wr_en    (w_wr_en),
        .i_wr_addr0 (r_tail),
        .i_wr_addr1 (w_tail_p1),
        .i_wr_data0 (w_wr_data0),
        .i_wr_data1 (w_wr_data1),
        .i_rd_addr0 (r_head),
        .i_rd_addr1 (w_head_p1),
        .o_rd_data0 (w_rd_data0),
        .o_rd_data1 (w_rd_data1)
    );

    always_comb begin
        w_out_valid = {(r_count >= CNT_W'(2)), (r_count != '0)};
        w_lane0     = w_rd_data0;
        w_lane1     = w_rd_data1;
        if (w_bypass) begin
            w_out_valid = {(in_valid == 2'b11), in_valid[0]};
            w_lane0     = in_entry[0];
            w_lane1     = in_entry[1];
        end
        out_valid    = w_out_valid;
        out_entry[0] = w_out_valid[0] ? w_lane0 : '0;
        out_entry[1] = w_out_valid[1] ? w_lane1 : '0;
    end

    // Lane1 may only retire together with lane0 to keep program order.
    assign w_pop0  = out_pop[0] && w_out_valid[0] && !flush;
    assign w_pop1  = w_pop0 && out_pop[1] && w_out_valid[1];
    assign w_pop_n = w_pop1 ? 2'd2 : (w_pop0 ? 2'd1 : 2'd0);

    // In bypass, popped lanes never touch the array; survivors pack at tail.
    always_comb begin
        w_wr_en    = {(w_push_n == 2'd2), (w_push_n != 2'd0)};
        w_wr_data0 = in_entry[0];
        w_wr_data1 = in_entry[1];
        w_head_adv = w_pop_n;
        w_tail_adv = w_push_n;
        if (w_bypass) begin
            w_head_adv = 2'd0;
            w_tail_adv = w_push_n - w_pop_n;
            if (w_pop_n == 2'd1) begin
                w_wr_en    = {1'b0, (w_push_n == 2'd2)};
                w_wr_data0 = in_entry[1];
            end else if (w_pop_n == 2'd2) begin
                w_wr_en = 2'b00;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_head_adv);
            r_tail  <= r_tail + PTR_W'(w_tail_adv);
            r_count <= r_count + CNT_W'(w_push_n) - CNT_W'(w_pop_n);
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue (default build, no bypass).
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 16;

    logic               clk;
    logic               resetn;
    logic               flush;
    logic [1:0]         in_valid;
    logic               in_ready;
    fetch_entry_t [1:0] in_entry;
    logic [1:0]         out_valid;
    fetch_entry_t [1:0] out_entry;
    logic [1:0]         out_pop;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] pc_n = 32'h1c001000;
    fetch_entry_t sb_q[$];

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_entry  (in_entry),
        .out_valid (out_valid),
        .out_entry (out_entry),
        .out_pop   (out_pop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic fetch_entry_t mk(input logic [31:0] pc);
        fetch_entry_t e;
        e = '0;
        e.pc                 = pc;
        e.inst               = pc ^ 32'h00ff_1234;
        e.pred_branch_taken  = pc[3];
        e.pred_branch_target = pc + 32'h40;
        return e;
    endfunction

    // Inputs applied at posedge+1, outputs checked at negedge, model updated at posedge.
    task automatic step(input logic [1:0] iv, input fetch_entry_t e0, input fetch_entry_t e1,
                        input logic [1:0] op, input logic fl);
        int sz;
        logic p0, p1;
        fetch_entry_t x0, x1;
        in_valid    = iv;
        in_entry[0] = e0;
        in_entry[1] = e1;
        out_pop     = op;
        flush       = fl;
        @(negedge clk);
        sz = sb_q.size();
        x0 = '0;
        x1 = '0;
        if (sz >= 1) x0 = sb_q[0];
        if (sz >= 2) x1 = sb_q[1];
        chk("out_valid", 128'(out_valid), 128'({(sz >= 2), (sz >= 1)}));
        chk("in_ready", 128'(in_ready), 128'(sz <= DEPTH - 2));
        chk("lane0", 128'(out_entry[0]), 128'(x0));
        chk("lane1", 128'(out_entry[1]), 128'(x1));
        @(posedge clk);
        if (fl) begin
            sb_q.delete();
        end else begin
            p0 = op[0] && (sz >= 1);
            p1 = p0 && op[1] && (sz >= 2);
            if (p0) void'(sb_q.pop_front());
            if (p1) void'(sb_q.pop_front());
            if (sz <= DEPTH - 2) begin
                if (iv[0]) sb_q.push_back(e0);
                if (iv == 2'b11) sb_q.push_back(e1);
            end
        end
        #1;
    endtask

    task automatic push_pair(input logic [1:0] op);
        step(2'b11, mk(pc_n), mk(pc_n + 32'd4), op, 1'b0);
        pc_n += 32'd8;
    endtask

    task automatic push_one(input logic [1:0] op);
        step(2'b01, mk(pc_n), mk(pc_n + 32'd4), op, 1'b0);
        pc_n += 32'd8;
    endtask

    task automatic idle(input logic [1:0] op);
        step(2'b00, '0, '0, op, 1'b0);
    endtask

    task automatic reset_dut();
        in_valid = 2'b00;
        out_pop  = 2'b00;
        flush    = 1'b0;
        in_entry = '0;
        resetn   = 1'b0;
        #2;
        chk("rst_out_valid", 128'(out_valid), 128'(2'b00));
        chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
        chk("rst_out_entry", 128'(out_entry[0]), 128'(0));
        @(posedge clk);
        #1;
        resetn = 1'b1;
        sb_q.delete();
    endtask

    initial begin
        fetch_entry_t ex0, ex1;
        resetn   = 1'b0;
        flush    = 1'b0;
        in_valid = 2'b00;
        out_pop  = 2'b00;
        in_entry = '0;
        #3;
        reset_dut();
        idle(2'b00);

        // Asynchronous reset with five entries held.
        push_pair(2'b00);
        push_pair(2'b00);
        push_one(2'b00);
        chk("pre_rst_valid", 128'(out_valid), 128'(2'b11));
        reset_dut();
        idle(2'b00);

        // Basic pair, visible one cycle after the push.
        step(2'b11, mk(32'h1c000000), mk(32'h1c000004), 2'b00, 1'b0);
        chk("pair_valid", 128'(out_valid), 128'(2'b11));
        chk("pair_pc0", 128'(out_entry[0].pc), 128'(32'h1c000000));
        chk("pair_pc1", 128'(out_entry[1].pc), 128'(32'h1c000004));
        idle(2'b11);
        idle(2'b00);

        // Fill to the in_ready boundary.
        for (int i = 0; i < 7; i++) push_pair(2'b00);
        push_one(2'b00);
        chk("full15_ready", 128'(in_ready), 128'(1'b0));
        push_one(2'b00);
        idle(2'b01);
        push_pair(2'b00);
        chk("full16_ready", 128'(in_ready), 128'(1'b0));
        push_pair(2'b00);
        idle(2'b11);
        push_pair(2'b11);
        for (int i = 0; i < 8; i++) idle(2'b11);

        // Wrap-around: head ends at 14, four entries span 14,15,0,1.
        reset_dut();
        for (int i = 0; i < 7; i++) push_pair(2'b00);
        for (int i = 0; i < 7; i++) idle(2'b11);
        push_pair(2'b00);
        push_pair(2'b00);
        idle(2'b01);
        chk("wrap_lane1_pc", 128'(out_entry[1].pc), 128'(pc_n - 32'd8));
        for (int i = 0; i < 3; i++) idle(2'b01);

        // Flush with count 7 and a same-cycle push.
        for (int i = 0; i < 3; i++) push_pair(2'b00);
        push_one(2'b00);
        step(2'b11, mk(32'hdead0000), mk(32'hdead0004), 2'b11, 1'b1);
        chk("flush_valid", 128'(out_valid), 128'(2'b00));
        chk("flush_ready", 128'(in_ready), 128'(1'b1));
        push_pair(2'b00);
        idle(2'b11);

        // Exception entry delivered unchanged, then a single-lane pop.
        ex0 = mk(32'h1c000200);
        ex0.have_exception     = 1'b1;
        ex0.exception_type     = EXC_ADEF;
        ex0.pred_branch_taken  = 1'b1;
        ex0.pred_branch_target = 32'h1c000100;
        ex1 = mk(32'h1c000204);
        step(2'b11, ex0, ex1, 2'b00, 1'b0);
        chk("exc_lane0", 128'(out_entry[0]), 128'(ex0));
        idle(2'b01);
        chk("exc_shift_valid", 128'(out_valid), 128'(2'b01));
        chk("exc_shift_pc", 128'(out_entry[0].pc), 128'(32'h1c000204));
        idle(2'b01);

        // Random traffic, including the non-thermometer 2'b10 mask.
        for (int i = 0; i < 300; i++) begin
            logic [1:0] iv, op;
            logic fl;
            iv = 2'($urandom_range(0, 3));
            op = 2'($urandom_range(0, 3));
            fl = ($urandom_range(0, 24) == 0);
            step(iv, mk(pc_n), mk(pc_n + 32'd4), op, fl);
            pc_n += 32'd8;
        end
        for (int i = 0; i < 9; i++) idle(2'b11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
